// File: rtl/filtered_line_feeder_pkg.sv
// Shared constants, state encoding and width helper for the filtered line feeder.
package filtered_line_feeder_pkg;

  localparam int kFilteredDataLength = 16;
  localparam int kNoOfPartitions     = 2;
  localparam int kPartitionSize      = 4;
  localparam int kLineLength         = kNoOfPartitions * kPartitionSize;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    FLUSH = 2'd1,
    HOLD  = 2'd2
  } feeder_state_t;

  // Bits needed to represent 0..value inclusive.
  function automatic int bin_width(input int value);
    return $clog2(value + 1);
  endfunction

endpackage

// File: rtl/filtered_line_feeder_sync_fifo.sv
// Small skid FIFO: registered occupancy, full/empty flags, head visible at the read port.
module sync_fifo #(
  parameter int pDataLength = 16,
  parameter int pDepth      = 4,
  parameter int pPtrLength  = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_push,
  input  logic [pDataLength-1:0] i_data,
  input  logic                   i_pop,
  output logic [pDataLength-1:0] o_head,
  output logic                   o_full,
  output logic                   o_empty
);

  logic [pDataLength-1:0] r_mem [pDepth];
  logic [pPtrLength-1:0]  r_wr_ptr;
  logic [pPtrLength-1:0]  r_rd_ptr;
  logic [pPtrLength:0]    r_count;
  logic                   w_push_ok;
  logic                   w_pop_ok;

  // Pushes into a full FIFO and pops from an empty one are dropped here.
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;

  assign o_full  = (r_count == (pPtrLength + 1)'(pDepth));
  assign o_empty = (r_count == (pPtrLength + 1)'(0));
  assign o_head  = r_mem[r_rd_ptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= pPtrLength'(0);
      r_rd_ptr <= pPtrLength'(0);
      r_count  <= (pPtrLength + 1)'(0);
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + pPtrLength'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + pPtrLength'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + (pPtrLength + 1)'(1);
        2'b01:   r_count <= r_count - (pPtrLength + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage write; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/filtered_line_feeder.sv
// Feeds filtered samples into the line buffer one shift per sample, then holds
// the completed line stable until the back-projection stage consumes it.
module filtered_line_feeder
  import filtered_line_feeder_pkg::*;
#(
  parameter int pDataLength    = kFilteredDataLength,
  parameter int pLineLength    = kLineLength,
  parameter int pCountLength   = bin_width(pLineLength),
  parameter int pFifoDepth     = 4,
  parameter int pFifoPtrLength = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [pDataLength-1:0]  in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [pDataLength-1:0]  lb_shift_in,
  output logic                    lb_enable,
  output logic                    line_loaded,
  input  logic                    line_consumed,
  output logic [pCountLength-1:0] sample_ptr,
  output logic                    protocol_error
);

  feeder_state_t           r_state;
  feeder_state_t           w_next_state;
  logic                    w_pop;
  logic                    w_consume;
  logic [pDataLength-1:0]  w_head;
  logic                    w_full;
  logic                    w_empty;
  logic [pDataLength-1:0]  r_shift_in;
  logic                    r_enable;
  logic                    r_loaded;
  logic [pCountLength-1:0] r_ptr;
  logic                    r_perr;

  sync_fifo #(
    .pDataLength (pDataLength),
    .pDepth      (pFifoDepth),
    .pPtrLength  (pFifoPtrLength)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (in_valid),
    .i_data  (in_data),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Ready depends only on registered occupancy, never on this cycle's pop.
  assign in_ready  = !w_full;
  assign w_consume = (r_state == HOLD) && line_consumed;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= FILL;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state and pop decision.
  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    case (r_state)
      FILL: begin
        if (!w_empty) begin
          w_pop = 1'b1;
          if (r_ptr == pCountLength'(pLineLength - 1)) begin
            w_next_state = FLUSH;
          end else begin
            w_next_state = FILL;
          end
        end else begin
          w_next_state = FILL;
        end
      end
      FLUSH: begin
        w_next_state = HOLD;
      end
      HOLD: begin
        if (line_consumed) begin
          w_next_state = FILL;
        end else begin
          w_next_state = HOLD;
        end
      end
      default: begin
        w_next_state = FILL;
      end
    endcase
  end

  // Registered line-buffer drive, sample counter and status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_shift_in <= pDataLength'(0);
      r_enable   <= 1'b0;
      r_loaded   <= 1'b0;
      r_ptr      <= pCountLength'(0);
      r_perr     <= 1'b0;
    end else begin
      r_enable <= w_pop;
      if (w_pop) r_shift_in <= w_head;
      if (w_pop) begin
        r_ptr <= r_ptr + pCountLength'(1);
      end else if (w_consume) begin
        r_ptr <= pCountLength'(0);
      end
      // line_loaded rises as the final shift pulse retires.
      if (r_state == FLUSH) begin
        r_loaded <= 1'b1;
      end else if (w_consume) begin
        r_loaded <= 1'b0;
      end
      if (line_consumed && !r_loaded) r_perr <= 1'b1;
    end
  end

  assign lb_shift_in    = r_shift_in;
  assign lb_enable      = r_enable;
  assign line_loaded    = r_loaded;
  assign sample_ptr     = r_ptr;
  assign protocol_error = r_perr;

endmodule

// File: tb/tb_filtered_line_feeder.sv
// Scoreboard bench for filtered_line_feeder: directed scenarios plus a random phase.
module tb_filtered_line_feeder;

  localparam int kDw    = 16;
  localparam int kLine  = 8;
  localparam int kDepth = 4;
  localparam int kCw    = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [kDw-1:0]  in_data;
  logic            in_valid;
  logic            in_ready;
  logic [kDw-1:0]  lb_shift_in;
  logic            lb_enable;
  logic            line_loaded;
  logic            line_consumed;
  logic [kCw-1:0]  sample_ptr;
  logic            protocol_error;

  logic man_c  = 1'b0;
  logic auto_c = 1'b0;
  logic auto_on = 1'b0;
  assign line_consumed = man_c | auto_c;

  always #5 clk = ~clk;

  filtered_line_feeder #(
    .pDataLength    (kDw),
    .pLineLength    (kLine),
    .pCountLength   (kCw),
    .pFifoDepth     (kDepth),
    .pFifoPtrLength (2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .lb_shift_in    (lb_shift_in),
    .lb_enable      (lb_enable),
    .line_loaded    (line_loaded),
    .line_consumed  (line_consumed),
    .sample_ptr     (sample_ptr),
    .protocol_error (protocol_error)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: samples accepted but not yet shifted, shifts done this line.
  logic [kDw-1:0] exp_q[$];
  int             cnt       = 0;
  bit             perr      = 1'b0;
  bit             exp_en    = 1'b0;
  bit             last_en   = 1'b0;
  bit             mon_en    = 1'b0;
  bit             loaded_pre;
  logic [kDw-1:0] last_data = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  // Model update at each edge (values seen before the edge).
  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      exp_q.delete();
      cnt       = 0;
      perr      = 1'b0;
      exp_en    = 1'b0;
      last_en   = 1'b0;
      last_data = '0;
      mon_en    = 1'b1;
    end else begin
      loaded_pre = (cnt == kLine) && !last_en;
      // A stored sample is shifted on this edge whenever the line is incomplete.
      exp_en = (cnt < kLine) && (exp_q.size() > 0);
      if (in_valid && in_ready) exp_q.push_back(in_data);
      if (line_consumed) begin
        if (loaded_pre) cnt = 0;
        else perr = 1'b1;
      end
    end
  end

  // Monitor: compare DUT outputs against the model mid-cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      check("lb_enable", 32'(lb_enable), 32'(exp_en));
      if (exp_en) begin
        last_data = exp_q.pop_front();
        check("lb_shift_in", 32'(lb_shift_in), 32'(last_data));
        cnt++;
      end else begin
        check("lb_shift_in_hold", 32'(lb_shift_in), 32'(last_data));
      end
      last_en = exp_en;
      check("sample_ptr", 32'(sample_ptr), cnt);
      check("line_loaded", 32'(line_loaded), 32'((cnt == kLine) && !exp_en));
      check("in_ready", 32'(in_ready), 32'(exp_q.size() < kDepth));
      check("protocol_error", 32'(protocol_error), 32'(perr));
    end
  end

  // Random downstream consumer, active only in the random phase.
  always @(negedge clk) begin
    if (auto_c) auto_c = 1'b0;
    else if (auto_on && line_loaded && ($urandom_range(0, 2) == 0)) auto_c = 1'b1;
    else auto_c = 1'b0;
  end

  task automatic send(input logic [kDw-1:0] d);
    int t;
    t = 0;
    in_data  = d;
    in_valid = 1'b1;
    forever begin
      @(posedge clk);
      if (in_ready) break;
      t++;
      if (t > 100) begin
        checks++;
        errors++;
        $display("FAIL send_timeout actual=stalled required=accepted cycle=%0d", cyc);
        break;
      end
    end
    #1 in_valid = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_loaded(output int seen);
    seen = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (line_loaded) begin
        seen = cyc;
        break;
      end
    end
    if (seen < 0) begin
      checks++;
      errors++;
      $display("FAIL wait_loaded actual=timeout required=line_loaded cycle=%0d", cyc);
    end
  endtask

  task automatic wait_ptr(input int v);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (int'(sample_ptr) == v) begin
        hit = 1'b1;
        break;
      end
    end
    if (!hit) begin
      checks++;
      errors++;
      $display("FAIL wait_ptr actual=timeout required=%0d cycle=%0d", v, cyc);
    end
  endtask

  task automatic pulse_consume();
    @(negedge clk);
    man_c = 1'b1;
    @(negedge clk);
    man_c = 1'b0;
  endtask

  task automatic bubbles(input int first, input int last);
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int k;
    k = 0;
    for (int n = first; n <= last; n++) begin
      while (!pat[k % 4]) begin
        idle();
        k++;
      end
      send(kDw'(16'hA0 + n));
      k++;
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual=running required=finished cycle=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c;
    int seen;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_lb_enable", 32'(lb_enable), 32'd0);
    check("rst_lb_shift_in", 32'(lb_shift_in), 32'd0);
    check("rst_line_loaded", 32'(line_loaded), 32'd0);
    check("rst_sample_ptr", 32'(sample_ptr), 32'd0);
    check("rst_protocol_error", 32'(protocol_error), 32'd0);
    idle();

    // Continuous fill: minimum load time is line length plus one.
    c = cyc;
    for (int i = 1; i <= kLine; i++) send(kDw'(i));
    wait_loaded(seen);
    check("t1_load_latency", seen - c, 32'd10);
    check("t1_sample_ptr", 32'(sample_ptr), 32'd8);

    // Backpressure while holding the line.
    idle();
    fork
      begin
        for (int v = 9; v <= 14; v++) send(kDw'(v));
      end
    join_none
    repeat (8) @(negedge clk);
    check("t2_in_ready_full", 32'(in_ready), 32'd0);
    check("t2_no_shift", 32'(lb_enable), 32'd0);
    pulse_consume();
    wait fork;

    // Bubbles: complete line 2, then a full bubbly line 3.
    bubbles(0, 1);
    wait_loaded(seen);
    pulse_consume();
    idle();
    bubbles(2, 9);
    wait_loaded(seen);
    check("t3_sample_ptr", 32'(sample_ptr), 32'd8);

    // Early consume sets the sticky error but loading continues.
    pulse_consume();
    idle();
    fork
      begin
        for (int i = 0; i < kLine; i++) send(kDw'($urandom));
      end
      begin
        wait_ptr(3);
        man_c = 1'b1;
        @(negedge clk);
        man_c = 1'b0;
      end
    join
    wait_loaded(seen);
    check("t4_protocol_error", 32'(protocol_error), 32'd1);
    check("t4_line_loaded", 32'(line_loaded), 32'd1);

    // Reset in the middle of a line.
    pulse_consume();
    idle();
    for (int i = 0; i < 10; i++) begin
      send(kDw'($urandom));
      if (int'(sample_ptr) >= 5) break;
    end
    pulse_reset();
    @(negedge clk);
    check("t5_sample_ptr", 32'(sample_ptr), 32'd0);
    check("t5_lb_enable", 32'(lb_enable), 32'd0);
    check("t5_in_ready", 32'(in_ready), 32'd1);
    check("t5_protocol_error", 32'(protocol_error), 32'd0);
    idle();
    for (int i = 0; i < kLine; i++) send(kDw'($urandom));
    wait_loaded(seen);

    // Consume and push on the same edge with three samples queued.
    idle();
    for (int i = 0; i < 3; i++) send(kDw'(16'h60 + i));
    in_data  = 16'h0063;
    in_valid = 1'b1;
    man_c    = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    man_c    = 1'b0;
    @(negedge clk);
    check("t6_line_loaded", 32'(line_loaded), 32'd0);
    check("t6_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("t6_first_pop", 32'(lb_enable), 32'd1);
    idle();

    // Random traffic with a random consumer.
    auto_on = 1'b1;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 2)) idle();
      send(kDw'($urandom));
    end
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !lb_enable) break;
    end
    check("drain", exp_q.size(), 32'd0);
    auto_on = 1'b0;
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
